// File: rtl/uart_rx_async_if.sv
// uart_rx_async_if
// Host-side bus of the UART receiver: the delivered byte, its status flags,
// the FIFO write strobe, and the CPU pulses that acknowledge/clear them.
//   rx_byte             receiver -> host   last received byte
//   receive_full        receiver -> host   byte waiting in the holding register
//   overflow            receiver -> host   sticky: a byte was lost
//   parity_err          receiver -> host   sticky: parity mismatch
//   framing_error       receiver -> host   sticky: stop bit sampled 0
//   fifo_write          receiver -> host   active-low one-clk RX FIFO write strobe
//   read_rx_byte        host -> receiver   clears receive_full and overflow
//   clear_parity        host -> receiver   clears parity_err
//   clear_framing_error host -> receiver   clears framing_error
//   fifo_full           host -> receiver   RX FIFO cannot accept a write
interface uart_rx_async_if;
   logic [7:0] rx_byte;
   logic       receive_full;
   logic       overflow;
   logic       parity_err;
   logic       framing_error;
   logic       fifo_write;
   logic       read_rx_byte;
   logic       clear_parity;
   logic       clear_framing_error;
   logic       fifo_full;

   modport master (
      input  rx_byte, receive_full, overflow, parity_err, framing_error, fifo_write,
      output read_rx_byte, clear_parity, clear_framing_error, fifo_full
   );

   modport slave (
      output rx_byte, receive_full, overflow, parity_err, framing_error, fifo_write,
      input  read_rx_byte, clear_parity, clear_framing_error, fifo_full
   );
endinterface

// File: rtl/uart_rx_async.sv
// uart_rx_async
// Asynchronous UART receiver. Oversamples rx at 16x baud (baud_clock enable),
// qualifies the start bit at its centre, shifts in 7 or 8 data bits LSB-first,
// optionally checks parity, checks the stop bit and delivers the byte either
// to a holding register (RX_FIFO = 0) or as a write strobe to an RX FIFO.
// Ports:
//   clk, reset_n       system clock, asynchronous active-low reset
//   baud_clock         one-clk enable at 16x the baud rate
//   rx                 serial input, asynchronous to clk
//   bit8               1 = 8 data bits, 0 = 7 data bits
//   parity_en          1 = parity bit follows the data bits
//   odd_n_even         1 = odd parity, 0 = even parity
//   host               host-side bus (byte, flags, FIFO strobe, clears)
module uart_rx_async #(
   parameter int RX_FIFO = 0
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            baud_clock,
   input  logic            rx,
   input  logic            bit8,
   input  logic            parity_en,
   input  logic            odd_n_even,
   uart_rx_async_if.slave  host
);

   typedef enum logic [1:0] {
      rx_idle,
      rx_data,
      rx_parity,
      rx_stop
   } rx_state_t;

   rx_state_t  state_q, state_d;
   logic       rx_meta_q, rx_meta_d;
   logic       rx_s_q, rx_s_d;
   logic [3:0] sample_cnt_q, sample_cnt_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       parity_acc_q, parity_acc_d;
   logic       parity_bad_q, parity_bad_d;
   logic [7:0] rx_byte_q, rx_byte_d;
   logic       receive_full_q, receive_full_d;
   logic       overflow_q, overflow_d;
   logic       parity_err_q, parity_err_d;
   logic       framing_error_q, framing_error_d;
   logic       fifo_write_q, fifo_write_d;

   logic       complete;
   logic [3:0] last_bit;
   logic [7:0] frame_byte;

   assign last_bit   = bit8 ? 4'd7 : 4'd6;
   // In 7-bit mode the data sits in shift[7:1] after seven right shifts.
   assign frame_byte = bit8 ? shift_q : {1'b0, shift_q[7:1]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= rx_idle;
         rx_meta_q       <= 1'b1;
         rx_s_q          <= 1'b1;
         sample_cnt_q    <= '0;
         bit_cnt_q       <= '0;
         shift_q         <= '0;
         parity_acc_q    <= 1'b0;
         parity_bad_q    <= 1'b0;
         rx_byte_q       <= '0;
         receive_full_q  <= 1'b0;
         overflow_q      <= 1'b0;
         parity_err_q    <= 1'b0;
         framing_error_q <= 1'b0;
         fifo_write_q    <= 1'b1;
      end else begin
         state_q         <= state_d;
         rx_meta_q       <= rx_meta_d;
         rx_s_q          <= rx_s_d;
         sample_cnt_q    <= sample_cnt_d;
         bit_cnt_q       <= bit_cnt_d;
         shift_q         <= shift_d;
         parity_acc_q    <= parity_acc_d;
         parity_bad_q    <= parity_bad_d;
         rx_byte_q       <= rx_byte_d;
         receive_full_q  <= receive_full_d;
         overflow_q      <= overflow_d;
         parity_err_q    <= parity_err_d;
         framing_error_q <= framing_error_d;
         fifo_write_q    <= fifo_write_d;
      end
   end

   // Frame sequencing. Entering rx_data happens at the start-bit centre, so
   // every following 16-pulse wrap lands on the centre of the next bit.
   always_comb begin
      state_d      = state_q;
      rx_meta_d    = rx;
      rx_s_d       = rx_meta_q;
      sample_cnt_d = sample_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      parity_acc_d = parity_acc_q;
      parity_bad_d = parity_bad_q;
      complete     = 1'b0;

      case (state_q)
         rx_idle: begin
            // A line that returns high before the start centre is a glitch.
            if (rx_s_q) begin
               sample_cnt_d = '0;
            end else if (baud_clock) begin
               if (sample_cnt_q == 4'd7) begin
                  state_d      = rx_data;
                  sample_cnt_d = '0;
                  bit_cnt_d    = '0;
                  shift_d      = '0;
                  parity_acc_d = 1'b0;
                  parity_bad_d = 1'b0;
               end else begin
                  sample_cnt_d = sample_cnt_q + 4'd1;
               end
            end
         end
         rx_data: begin
            if (baud_clock) begin
               sample_cnt_d = sample_cnt_q + 4'd1;
               if (sample_cnt_q == 4'd15) begin
                  shift_d      = {rx_s_q, shift_q[7:1]};
                  parity_acc_d = parity_acc_q ^ rx_s_q;
                  bit_cnt_d    = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == last_bit) begin
                     state_d = parity_en ? rx_parity : rx_stop;
                  end
               end
            end
         end
         rx_parity: begin
            if (baud_clock) begin
               sample_cnt_d = sample_cnt_q + 4'd1;
               if (sample_cnt_q == 4'd15) begin
                  parity_bad_d = rx_s_q ^ odd_n_even ^ parity_acc_q;
                  state_d      = rx_stop;
               end
            end
         end
         rx_stop: begin
            // Back to idle at the stop centre so the next start edge can be
            // tracked during the second half of the stop bit.
            if (baud_clock) begin
               sample_cnt_d = sample_cnt_q + 4'd1;
               if (sample_cnt_q == 4'd15) begin
                  complete = 1'b1;
                  state_d  = rx_idle;
               end
            end
         end
         default: state_d = rx_idle;
      endcase
   end

   // Delivery and sticky flags. Clears are applied first so a completion on
   // the same clk wins; a read on the completion clk still forgives overflow.
   always_comb begin
      rx_byte_d       = rx_byte_q;
      receive_full_d  = receive_full_q;
      overflow_d      = overflow_q;
      parity_err_d    = parity_err_q;
      framing_error_d = framing_error_q;
      fifo_write_d    = 1'b1;

      if (host.read_rx_byte) begin
         receive_full_d = 1'b0;
         overflow_d     = 1'b0;
      end
      if (host.clear_parity) begin
         parity_err_d = 1'b0;
      end
      if (host.clear_framing_error) begin
         framing_error_d = 1'b0;
      end

      if (complete) begin
         rx_byte_d = frame_byte;
         if (parity_bad_q) begin
            parity_err_d = 1'b1;
         end
         if (!rx_s_q) begin
            framing_error_d = 1'b1;
         end
         if (RX_FIFO != 0) begin
            if (host.fifo_full) begin
               overflow_d = 1'b1;
            end else begin
               fifo_write_d = 1'b0;
            end
         end else begin
            receive_full_d = 1'b1;
            if (receive_full_q && !host.read_rx_byte) begin
               overflow_d = 1'b1;
            end
         end
      end
   end

   assign host.rx_byte       = rx_byte_q;
   assign host.receive_full  = receive_full_q;
   assign host.overflow      = overflow_q;
   assign host.parity_err    = parity_err_q;
   assign host.framing_error = framing_error_q;
   assign host.fifo_write    = fifo_write_q;

endmodule
